// File: rtl/cnt_clkdiv_if.sv
// cnt_clkdiv_if: control/status bundle for the prescaled counter
//   restart, top            : driven by the master (counter clear, terminal count)
//   tick, div_clk, count, done : driven by the core (slave)
`timescale 1ns/1ps
interface cnt_clkdiv_if #(parameter int WIDTH = 8) ();
  logic restart;
  logic [WIDTH-1:0] top;
  logic tick;
  logic div_clk;
  logic [WIDTH-1:0] count;
  logic done;
  modport master(output restart, top, input tick, div_clk, count, done);
  modport slave(input restart, top, output tick, div_clk, count, done);
endinterface

// File: rtl/cnt_clkdiv_core.sv
// cnt_clkdiv_core: sys_clk prescaler with tick/div_clk and a wrapping or locking up-counter
//   sys_clk : system clock, all state on its rising edge
//   rst     : asynchronous active-high reset
//   bus     : restart/top in; tick, div_clk, count, done out
`timescale 1ns/1ps
module cnt_clkdiv_core #(
  parameter int DIV = 50000000,
  parameter int WIDTH = 8,
  parameter bit FREERUN = 1'b1
) (
  input logic sys_clk,
  input logic rst,
  cnt_clkdiv_if.slave bus
);
  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] HI = PW'(DIV - DIV / 2);
  logic [PW-1:0] pre, pre_nxt;
  logic [WIDTH-1:0] count, inc;
  logic tick, div_clk, done;
  assign tick = pre == LAST;
  assign pre_nxt = tick ? '0 : pre + 1'b1;
  assign inc = count + 1'b1;
  // div_clk is decoded from the next prescaler value so the register tracks the current one
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      pre <= '0;
      div_clk <= 1'b0;
    end else begin
      pre <= pre_nxt;
      div_clk <= pre_nxt >= HI;
    end
  always_ff @(posedge sys_clk or posedge rst)
    if (rst) begin
      count <= '0;
      done <= 1'b0;
    end else if (bus.restart) begin
      count <= '0;
      done <= 1'b0;
    end else if (!tick) begin
      if (FREERUN) done <= 1'b0;
    end else if (count == bus.top) begin
      if (FREERUN) count <= '0;
      done <= 1'b1;
    end else begin
      count <= inc;
      done <= !FREERUN && inc == bus.top;
    end
  assign bus.tick = tick;
  assign bus.div_clk = div_clk;
  assign bus.count = count;
  assign bus.done = done;
endmodule

// File: tb/tb_cnt_clkdiv_core.sv
// tb_cnt_clkdiv_core: scoreboard bench for three counter configurations
`timescale 1ns/1ps
module tb_cnt_clkdiv_core;
  logic sys_clk = 1'b0;
  logic rst = 1'b1;
  always #1 sys_clk = ~sys_clk;
  cnt_clkdiv_if #(.WIDTH(4)) b0 ();
  cnt_clkdiv_if #(.WIDTH(2)) b1 ();
  cnt_clkdiv_if #(.WIDTH(3)) b2 ();
  cnt_clkdiv_core #(.DIV(4), .WIDTH(4), .FREERUN(1'b1)) d0 (.sys_clk(sys_clk), .rst(rst), .bus(b0));
  cnt_clkdiv_core #(.DIV(4), .WIDTH(2), .FREERUN(1'b0)) d1 (.sys_clk(sys_clk), .rst(rst), .bus(b1));
  cnt_clkdiv_core #(.DIV(5), .WIDTH(3), .FREERUN(1'b1)) d2 (.sys_clk(sys_clk), .rst(rst), .bus(b2));
  localparam int DV[3] = '{4, 4, 5};
  localparam int WD[3] = '{4, 2, 3};
  localparam int FR[3] = '{1, 0, 1};
  typedef struct {int tick; int dclk; int cnt; int done;} obs_t;
  typedef struct {int pre; int cnt; int done;} ms_t;
  obs_t q[$];
  ms_t ms[3];
  int n_cmp = 0;
  int n_bad = 0;
  task automatic chk(string tag, int got, int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at t=%0t", tag, got, want, $time);
    end
  endtask
  function automatic int top_of(int i);
    return i == 0 ? int'(b0.top) : i == 1 ? int'(b1.top) : int'(b2.top);
  endfunction
  function automatic bit rs_of(int i);
    return i == 0 ? b0.restart : i == 1 ? b1.restart : b2.restart;
  endfunction
  function automatic obs_t dut(int i);
    obs_t o;
    o.tick = i == 0 ? int'(b0.tick) : i == 1 ? int'(b1.tick) : int'(b2.tick);
    o.dclk = i == 0 ? int'(b0.div_clk) : i == 1 ? int'(b1.div_clk) : int'(b2.div_clk);
    o.cnt = i == 0 ? int'(b0.count) : i == 1 ? int'(b1.count) : int'(b2.count);
    o.done = i == 0 ? int'(b0.done) : i == 1 ? int'(b1.done) : int'(b2.done);
    return o;
  endfunction
  function automatic obs_t view(ms_t m, int i);
    obs_t o;
    o.tick = int'(m.pre == DV[i] - 1);
    o.dclk = int'(m.pre >= DV[i] - DV[i] / 2);
    o.cnt = m.cnt;
    o.done = m.done;
    return o;
  endfunction
  function automatic ms_t step(ms_t m, int i, bit rs, int top);
    ms_t n = m;
    bit t = m.pre == DV[i] - 1;
    n.pre = t ? 0 : m.pre + 1;
    if (rs) begin
      n.cnt = 0;
      n.done = 0;
    end else if (!t) begin
      if (FR[i] == 1) n.done = 0;
    end else if (m.cnt == top) begin
      if (FR[i] == 1) n.cnt = 0;
      n.done = 1;
    end else begin
      n.cnt = (m.cnt + 1) % (1 << WD[i]);
      n.done = (FR[i] == 0 && n.cnt == top) ? 1 : 0;
    end
    return n;
  endfunction
  always @(posedge sys_clk)
    for (int i = 0; i < 3; i++) begin
      ms_t n;
      n = rst ? '{0, 0, 0} : step(ms[i], i, rs_of(i), top_of(i));
      q.push_back(view(n, i));
      ms[i] <= n;
    end
  always @(negedge sys_clk)
    if (q.size() >= 3)
      for (int i = 0; i < 3; i++) begin
        obs_t e, g;
        e = q.pop_front();
        g = dut(i);
        chk($sformatf("d%0d.tick", i), g.tick, e.tick);
        chk($sformatf("d%0d.div_clk", i), g.dclk, e.dclk);
        chk($sformatf("d%0d.count", i), g.cnt, e.cnt);
        chk($sformatf("d%0d.done", i), g.done, e.done);
      end
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    b0.restart = 1'b0; b1.restart = 1'b0; b2.restart = 1'b0;
    b0.top = 4'd15; b1.top = 2'd3; b2.top = 3'd7;
    #2 rst = 1'b0;
    chk("reset_count", int'(b0.count), 0);
    repeat (68) @(negedge sys_clk);
    chk("lock_count", int'(b1.count), 3);
    chk("lock_done", int'(b1.done), 1);
    b1.restart = 1'b1;
    @(negedge sys_clk);
    b1.restart = 1'b0;
    chk("restart_count", int'(b1.count), 0);
    chk("restart_done", int'(b1.done), 0);
    repeat (12) @(negedge sys_clk);
    k = 0;
    while (!b0.tick && k < 8) begin
      @(negedge sys_clk);
      k++;
    end
    chk("tick_seen", int'(b0.tick), 1);
    b0.restart = 1'b1;
    @(negedge sys_clk);
    b0.restart = 1'b0;
    chk("restart_tick_count", int'(b0.count), 0);
    repeat (4) @(negedge sys_clk);
    chk("resume_count", int'(b0.count), 1);
    b2.restart = 1'b1;
    @(negedge sys_clk);
    b2.restart = 1'b0;
    k = 0;
    while (b2.count != 3'd5 && k < 60) begin
      @(negedge sys_clk);
      k++;
    end
    chk("reach_five", int'(b2.count), 5);
    @(negedge sys_clk);
    #0.4 rst = 1'b1;
    #0.2;
    chk("async_count", int'(b2.count), 0);
    chk("async_tick", int'(b2.tick), 0);
    chk("async_div_clk", int'(b2.div_clk), 0);
    chk("async_done", int'(b2.done), 0);
    chk("async_count_d1", int'(b1.count), 0);
    @(negedge sys_clk);
    #0.5 rst = 1'b0;
    k = 0;
    while (!b2.tick && k < 20) begin
      @(posedge sys_clk);
      #0.1;
      k++;
    end
    chk("first_tick_cycles", k, 4);
    @(negedge sys_clk);
    b0.restart = 1'b1;
    b0.top = 4'd0;
    @(negedge sys_clk);
    b0.restart = 1'b0;
    repeat (20) @(negedge sys_clk);
    chk("top0_count", int'(b0.count), 0);
    chk("relock3_count", int'(b1.count), 3);
    b1.top = 2'd2;
    repeat (24) @(negedge sys_clk);
    chk("relock2_count", int'(b1.count), 2);
    chk("relock2_done", int'(b1.done), 1);
    repeat (2) @(negedge sys_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
